// File: rtl/dec_pkg.sv
// Shared types and constants for the decimal up-counting stopwatch.
package dec_pkg;
  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int HUND_MAX = 99;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;

  // Two-digit BCD encoding of a small integer (tens in the high nibble).
  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
endpackage

// File: rtl/bcd_mod_pair.sv
// Two-digit BCD counter that wraps to 00 after MAX; carry_out marks the wrap.
module bcd_mod_pair
  import dec_pkg::*;
#(
  parameter int MAX = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_in,
  input  logic       clr,
  output bcd_t [1:0] cnt,
  output logic       carry_out
);
  localparam logic [7:0] MAX_BCD = to_bcd2(MAX);

  bcd_t [1:0] cnt_q, cnt_d;
  logic       at_max;

  assign at_max    = (cnt_q == MAX_BCD);
  assign carry_out = inc_in && at_max;
  assign cnt       = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc_in) begin
      if (at_max) begin
        cnt_d = '0;
      end else if (cnt_q[0] >= 4'd9) begin
        cnt_d[0] = 4'd0;
        cnt_d[1] = cnt_q[1] + 4'd1;
      end else begin
        cnt_d[0] = cnt_q[0] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dec_up_stopwatch.sv
// MM:SS.hh stopwatch: run/pause FSM, hundredth-second prescaler, lap freeze.
module dec_up_stopwatch
  import dec_pkg::*;
#(
  parameter int TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output bcd_t [5:0] out,
  output logic       running,
  output logic       done,
  output logic       held
);
  localparam int            PW        = 24;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  // Count value one tick before the terminal 59:59.99.
  localparam logic [23:0]   LAST_M1   = {to_bcd2(MIN_MAX), to_bcd2(SEC_MAX), to_bcd2(HUND_MAX - 1)};

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          held_q, held_d;
  bcd_t [5:0]    lap_q, lap_d;
  bcd_t [5:0]    cnt;

  logic clr_eff, ss_eff, lap_eff, tick, last_tick;
  logic hund_carry, sec_carry, min_wrap;

  // clear beats start_stop beats lap
  assign clr_eff   = clear && (state_q != RUN);
  assign ss_eff    = start_stop && !clr_eff && (state_q != DONE);
  assign lap_eff   = lap && !ss_eff && (state_q == RUN);
  assign tick      = (state_q == RUN) && (presc_q == PRESC_MAX);
  assign last_tick = (tick && (cnt == LAST_M1)) || min_wrap;

  bcd_mod_pair #(.MAX(HUND_MAX)) u_hund (
    .clk(clk), .rst(rst), .inc_in(tick), .clr(clr_eff),
    .cnt(cnt[1:0]), .carry_out(hund_carry)
  );
  bcd_mod_pair #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .inc_in(hund_carry), .clr(clr_eff),
    .cnt(cnt[3:2]), .carry_out(sec_carry)
  );
  bcd_mod_pair #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .inc_in(sec_carry), .clr(clr_eff),
    .cnt(cnt[5:4]), .carry_out(min_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_eff) state_d = RUN;
      RUN:     if (last_tick) state_d = DONE;
               else if (ss_eff) state_d = PAUSE;
      PAUSE:   if (clr_eff) state_d = IDLE;
               else if (ss_eff) state_d = RUN;
      DONE:    if (clr_eff) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    running = (state_q == RUN);
    done    = (state_q == DONE);
    held    = held_q;
    out     = held_q ? lap_q : cnt;
  end

  always_comb begin
    presc_d = presc_q;
    held_d  = held_q;
    lap_d   = lap_q;
    if (clr_eff) begin
      presc_d = '0;
      held_d  = 1'b0;
    end else begin
      if (state_q == RUN) presc_d = tick ? '0 : presc_q + PW'(1);
      if (last_tick) begin
        held_d = 1'b0;
      end else if (lap_eff) begin
        held_d = !held_q;
        if (!held_q) lap_d = cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      held_q  <= 1'b0;
      lap_q   <= '0;
    end else begin
      presc_q <= presc_d;
      held_q  <= held_d;
      lap_q   <= lap_d;
    end
  end
endmodule

// File: tb/tb_dec_up_stopwatch.sv
// Directed bench for dec_up_stopwatch with TICK_DIV=4 (one hundredth per 4 clks).
module tb_dec_up_stopwatch;
  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start_stop = 1'b0;
  logic            clear = 1'b0;
  logic            lap = 1'b0;
  logic [5:0][3:0] out;
  logic            running, done, held;
  int              n_chk = 0;
  int              n_pass = 0;

  dec_up_stopwatch #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .out(out), .running(running), .done(done), .held(held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic c, input logic l);
    start_stop = s; clear = c; lap = l;
    step(1);
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  // flags packed as {running, done, held}
  task automatic chk_st(input string tag, input logic [23:0] exp_out, input logic [2:0] exp_fl);
    chk({tag, "_out"}, 32'(out), 32'(exp_out));
    chk({tag, "_flags"}, 32'({running, done, held}), 32'(exp_fl));
  endtask

  initial begin
    #12;
    chk_st("reset", 24'h000000, 3'b000);
    @(negedge clk); rst = 1'b1;

    pulse(1, 0, 0);
    step(400);
    chk_st("run400", 24'h000100, 3'b100);

    pulse(1, 0, 0);
    pulse(0, 1, 0);
    chk_st("clr_idle", 24'h000000, 3'b000);

    // lap freeze
    pulse(1, 0, 0);
    step(20);
    chk_st("pre_lap", 24'h000005, 3'b100);
    pulse(0, 0, 1);
    chk_st("lap_set", 24'h000005, 3'b101);
    step(19);
    chk_st("lap_frozen", 24'h000005, 3'b101);
    step(20);
    pulse(0, 0, 1);
    chk_st("lap_rel", 24'h000015, 3'b100);

    pulse(0, 1, 0);
    chk_st("clr_in_run", 24'h000015, 3'b100);
    pulse(1, 0, 0);
    step(3);
    chk_st("pause_hold", 24'h000015, 3'b000);
    pulse(0, 1, 0);
    chk_st("clr_pause", 24'h000000, 3'b000);

    pulse(1, 0, 0);
    step(5);
    chk_st("restart", 24'h000001, 3'b100);
    pulse(1, 0, 0);
    pulse(1, 1, 0);
    chk_st("clr_ss", 24'h000000, 3'b000);
    step(8);
    chk_st("clr_ss_stay", 24'h000000, 3'b000);

    // pause with prescaler sampled at 2, resume ticks one clk later
    pulse(1, 0, 0);
    step(2);
    pulse(1, 0, 0);
    step(5);
    chk_st("pause2", 24'h000000, 3'b000);
    pulse(1, 0, 0);
    chk_st("resume", 24'h000000, 3'b100);
    step(1);
    chk_st("resume_tick", 24'h000001, 3'b100);
    step(20);
    chk_st("pre_rst", 24'h000006, 3'b100);

    // asynchronous reset between edges
    #2 rst = 1'b0;
    #1 chk_st("async_rst", 24'h000000, 3'b000);
    @(negedge clk);
    rst = 1'b1; start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    chk_st("post_rst", 24'h000000, 3'b100);

    step(23996);
    chk_st("to_59_99", 24'h005999, 3'b100);
    step(4);
    chk_st("min_carry", 24'h010000, 3'b100);

    pulse(1, 0, 0);
    force dut.u_min.cnt_q  = 8'h59;
    force dut.u_sec.cnt_q  = 8'h59;
    force dut.u_hund.cnt_q = 8'h98;
    step(1);
    release dut.u_min.cnt_q;
    release dut.u_sec.cnt_q;
    release dut.u_hund.cnt_q;
    step(1);
    chk_st("preload", 24'h595998, 3'b000);
    pulse(1, 0, 0);
    step(2);
    chk_st("pre_done", 24'h595998, 3'b100);
    step(1);
    chk_st("done", 24'h595999, 3'b010);
    step(8);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    chk_st("done_hold", 24'h595999, 3'b010);
    pulse(0, 1, 0);
    chk_st("done_clr", 24'h000000, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
